// File: rtl/tt_um_islam_ihfaz_mealy_tx_if.sv
// ============================================================================
// Module      : tt_um_islam_ihfaz_mealy_tx_if
// Description : Pin bundle between the frame transmitter and its host.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tt_um_islam_ihfaz_mealy_tx_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

`default_nettype wire

// File: rtl/tt_um_islam_ihfaz_mealy_tx.sv
// ============================================================================
// Module      : tt_um_islam_ihfaz_mealy_tx
// Description : 4-deep FIFO feeding continuous 3-bit parity-marked frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_islam_ihfaz_mealy_tx (
  input  logic                               clk,
  input  logic                               rst_n,
  tt_um_islam_ihfaz_mealy_tx_if.slave        bus
);

  localparam logic [1:0] SLOT_B0    = 2'd0;
  localparam logic [1:0] SLOT_B1    = 2'd1;
  localparam logic [1:0] SLOT_B2    = 2'd2;
  localparam logic [2:0] FIFO_DEPTH = 3'd4;
  localparam logic [2:0] IDLE_FRAME = 3'b000;

  logic [1:0] r_slot;
  logic [2:0] r_frame;
  logic [2:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       r_overflow;

  logic       w_b0;
  logic       w_b1;
  logic       w_mark;
  logic       w_valid;
  logic       w_clr;
  logic       w_ready;
  logic       w_push;
  logic       w_load;
  logic       w_pop;
  logic [2:0] w_new_frame;
  logic       w_x;
  logic       w_frame_start;
  logic       w_z_exp;
  logic       unused_ok;

  assign w_b0    = bus.ui_in[0];
  assign w_b1    = bus.ui_in[1];
  assign w_mark  = bus.ui_in[2];
  assign w_valid = bus.ui_in[3];
  assign w_clr   = bus.ui_in[4];

  assign w_ready = (r_count < FIFO_DEPTH);
  assign w_push  = w_valid & w_ready;
  assign w_load  = (r_slot == SLOT_B2);
  // Pop looks at the registered count, so a word pushed on this edge into an
  // empty FIFO is never bypassed into the frame being loaded.
  assign w_pop   = w_load & (r_count != 3'd0);

  // Third bit makes b0^b1^b2 equal the mark, which is what the detector reports.
  assign w_new_frame = {w_b0, w_b1, w_b0 ^ w_b1 ^ w_mark};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= SLOT_B0;
    end else if (w_load) begin
      r_slot <= SLOT_B0;
    end else begin
      r_slot <= r_slot + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= IDLE_FRAME;
    end else if (w_load) begin
      r_frame <= w_pop ? r_mem[r_rd_ptr] : IDLE_FRAME;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_new_frame;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_valid && !w_ready) begin
      r_overflow <= 1'b1;
    end else if (w_clr) begin
      r_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_x = r_frame[0];
    case (r_slot)
      SLOT_B0: w_x = r_frame[2];
      SLOT_B1: w_x = r_frame[1];
      default: w_x = r_frame[0];
    endcase
  end

  assign w_frame_start = (r_slot == SLOT_B0);
  assign w_z_exp       = (r_slot == SLOT_B2) & (^r_frame);

  assign bus.uo_out  = {r_overflow, r_count, w_ready, w_z_exp, w_frame_start, w_x};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

  assign unused_ok = ^{1'b0, bus.ena, bus.ui_in[7:5], bus.uio_in};

endmodule

`default_nettype wire

// File: tb/tb_tt_um_islam_ihfaz_mealy_tx.sv
// ============================================================================
// Module      : tb_tt_um_islam_ihfaz_mealy_tx
// Description : Directed vector table, corner sequences and detector loopback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_um_islam_ihfaz_mealy_tx;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tt_um_islam_ihfaz_mealy_tx_if bus ();

  tt_um_islam_ihfaz_mealy_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       b0;
    logic       b1;
    logic       mark;
    logic       clr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       lb_on  = 1'b0;
  int         lb_k   = 0;
  logic       lb_acc = 1'b0;

  // uo_out image: {overflow, count, ready, z_exp, frame_start, x}
  function automatic logic [7:0] mk(input logic x, input logic fs, input logic z,
                                    input logic rdy, input logic [2:0] cnt,
                                    input logic ovf);
    return {ovf, cnt, rdy, z, fs, x};
  endfunction

  function automatic void add(input logic v, input logic b0, input logic b1,
                              input logic m, input logic c,
                              input logic x, input logic fs, input logic z,
                              input logic rdy, input logic [2:0] cnt,
                              input logic ovf);
    vec_t t;
    t.valid = v;
    t.b0    = b0;
    t.b1    = b1;
    t.mark  = m;
    t.clr   = c;
    t.exp   = mk(x, fs, z, rdy, cnt, ovf);
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b0, input logic b1,
                       input logic m, input logic c);
    bus.ui_in = {3'b000, c, v, m, b1, b0};
  endtask

  task automatic step(input logic v, input logic b0, input logic b1,
                      input logic m, input logic c);
    drive(v, b0, b1, m, c);
    @(posedge clk);
    #1;
  endtask

  // Reference detector on the serial line: output in slot 2 is b0^b1^x.
  always @(negedge clk) begin
    if (lb_on) begin
      if (lb_k == 0) lb_acc = bus.uo_out[0];
      else           lb_acc = lb_acc ^ bus.uo_out[0];
      if (lb_k == 2) check("loopback_z", {7'b0, bus.uo_out[2]}, {7'b0, lb_acc});
      else           check("loopback_z_off", {7'b0, bus.uo_out[2]}, 8'h00);
      lb_k = (lb_k == 2) ? 0 : lb_k + 1;
    end
  end

  initial begin
    int accepted;
    int cycles;
    logic v;

    bus.ena    = 1'b1;
    bus.uio_in = 8'h00;
    drive(0, 0, 0, 0, 0);

    // Idle after reset, then marked frames, ordering, full/overflow.
    for (int k = 1; k <= 9; k++) add(0,0,0,0,0, 0,(k % 3 == 0),0,1,3'd0,0);
    add(1,1,0,1,0, 0,0,0,1,3'd1,0);
    add(0,0,0,0,0, 0,0,0,1,3'd1,0);
    add(0,0,0,0,0, 1,1,0,1,3'd0,0);
    add(1,1,1,0,0, 0,0,0,1,3'd1,0);
    add(0,0,0,0,0, 0,0,1,1,3'd1,0);
    add(0,0,0,0,0, 1,1,0,1,3'd0,0);
    add(0,0,0,0,0, 1,0,0,1,3'd0,0);
    add(0,0,0,0,0, 0,0,0,1,3'd0,0);
    add(0,0,0,0,0, 0,1,0,1,3'd0,0);
    add(1,0,0,1,0, 0,0,0,1,3'd1,0);
    add(1,1,0,0,0, 0,0,0,1,3'd2,0);
    add(1,1,1,1,0, 0,1,0,1,3'd2,0);
    add(0,0,0,0,0, 0,0,0,1,3'd2,0);
    add(0,0,0,0,0, 1,0,1,1,3'd2,0);
    add(0,0,0,0,0, 1,1,0,1,3'd1,0);
    add(0,0,0,0,0, 0,0,0,1,3'd1,0);
    add(0,0,0,0,0, 1,0,0,1,3'd1,0);
    add(0,0,0,0,0, 1,1,0,1,3'd0,0);
    add(0,0,0,0,0, 1,0,0,1,3'd0,0);
    add(0,0,0,0,0, 1,0,1,1,3'd0,0);
    add(0,0,0,0,0, 0,1,0,1,3'd0,0);
    add(0,0,0,0,0, 0,0,0,1,3'd0,0);
    add(0,0,0,0,0, 0,0,0,1,3'd0,0);
    add(0,0,0,0,0, 0,1,0,1,3'd0,0);
    add(1,1,1,0,0, 0,0,0,1,3'd1,0);
    add(1,0,1,1,0, 0,0,0,1,3'd2,0);
    add(1,1,0,1,0, 1,1,0,1,3'd2,0);
    add(1,0,0,0,0, 1,0,0,1,3'd3,0);
    add(1,1,1,1,0, 0,0,0,0,3'd4,0);
    add(1,1,0,0,0, 0,1,0,1,3'd3,1);
    add(1,0,1,0,0, 1,0,0,0,3'd4,1);
    add(1,0,0,1,1, 0,0,1,0,3'd4,1);
    add(0,0,0,0,0, 1,1,0,1,3'd3,1);
    add(0,0,0,0,1, 0,0,0,1,3'd3,0);
    add(0,0,0,0,0, 0,0,1,1,3'd3,0);
    add(0,0,0,0,0, 0,1,0,1,3'd2,0);
    add(0,0,0,0,0, 0,0,0,1,3'd2,0);
    add(0,0,0,0,0, 0,0,0,1,3'd2,0);
    add(0,0,0,0,0, 1,1,0,1,3'd1,0);
    add(0,0,0,0,0, 1,0,0,1,3'd1,0);
    add(0,0,0,0,0, 1,0,1,1,3'd1,0);
    add(0,0,0,0,0, 0,1,0,1,3'd0,0);
    add(0,0,0,0,0, 1,0,0,1,3'd0,0);
    add(0,0,0,0,0, 1,0,0,1,3'd0,0);
    add(0,0,0,0,0, 0,1,0,1,3'd0,0);

    #2;
    check("reset_state", bus.uo_out, mk(0,1,0,1,3'd0,0));
    check("uio_out", bus.uio_out, 8'h00);
    check("uio_oe", bus.uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].valid, vecs[i].b0, vecs[i].b1, vecs[i].mark, vecs[i].clr);
      check($sformatf("vec%0d", i + 1), bus.uo_out, vecs[i].exp);
    end

    // Push on the slot-2 edge into an empty FIFO: idle frame first, no bypass.
    step(0,0,0,0,0);
    step(0,0,0,0,0);
    step(1,1,0,1,0); check("empty_pop_push", bus.uo_out, mk(0,1,0,1,3'd1,0));
    step(0,0,0,0,0); check("empty_idle_b1",  bus.uo_out, mk(0,0,0,1,3'd1,0));
    step(0,0,0,0,0); check("empty_idle_b2",  bus.uo_out, mk(0,0,0,1,3'd1,0));
    step(0,0,0,0,0); check("empty_word_b0",  bus.uo_out, mk(1,1,0,1,3'd0,0));
    step(0,0,0,0,0); check("empty_word_b1",  bus.uo_out, mk(0,0,0,1,3'd0,0));
    step(0,0,0,0,0); check("empty_word_b2",  bus.uo_out, mk(0,0,1,1,3'd0,0));

    // Asynchronous reset during slot 1 with three words queued.
    step(0,0,0,0,0);
    step(1,1,1,1,0);
    step(1,0,0,0,0);
    step(1,1,0,0,0);
    step(1,0,1,1,0); check("pre_reset", bus.uo_out, mk(1,0,0,1,3'd3,0));
    drive(0,0,0,0,0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", bus.uo_out, mk(0,1,0,1,3'd0,0));
    @(negedge clk);
    rst_n = 1'b1;
    check("post_release", bus.uo_out, mk(0,1,0,1,3'd0,0));
    step(0,0,0,0,0); check("post_reset_b1", bus.uo_out, mk(0,0,0,1,3'd0,0));
    step(0,0,0,0,0); check("post_reset_b2", bus.uo_out, mk(0,0,0,1,3'd0,0));
    step(0,0,0,0,0); check("post_reset_b0", bus.uo_out, mk(0,1,0,1,3'd0,0));

    // Loopback against the reference detector with random pushes.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    lb_k   = 0;
    lb_on  = 1'b1;
    accepted = 0;
    cycles   = 0;
    while (accepted < 200 && cycles < 2000) begin
      v = ($urandom_range(0, 2) == 0);
      if (v && bus.uo_out[3]) accepted++;
      step(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b1);
      cycles++;
    end
    check("loopback_push_budget", {7'b0, (accepted >= 200)}, 8'h01);
    for (int i = 0; i < 15; i++) step(0,0,0,0,0);
    lb_on = 1'b0;
    check("drained", bus.uo_out[6:3], 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
